// File: rtl/gray_to_bcd_serial_if.sv
// Stream bundle for the serial Gray decoder: serial Gray bit input, decoded word output, status.
// The master modport is the link/consumer side; the slave modport is the decoder.
interface gray_to_bcd_serial_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             g_in;
  logic             g_start;
  logic             g_valid;
  logic             g_ready;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             bin_ready;
  logic             bcd_err;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output g_in, g_start, g_valid, bin_ready,
    input  g_ready, bin_out, bin_valid, bcd_err, err_count, busy
  );

  modport slave (
    input  g_in, g_start, g_valid, bin_ready,
    output g_ready, bin_out, bin_valid, bcd_err, err_count, busy
  );
endinterface

// File: rtl/gray_to_bcd_serial.sv
// Serial MSB-first Gray-to-binary decoder with a registered valid/ready result,
// a BCD range flag and a saturating count of out-of-range words.
module gray_to_bcd_serial #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  gray_to_bcd_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-2:0] shift_reg;
  logic             prev_bit;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] bin_reg;
  logic             bcd_reg;
  logic [CNT_W-1:0] err_reg;

  logic             bit_xfer;
  logic             out_xfer;
  logic             dec_bit;
  logic             last_bit;
  logic             word_err;
  logic [WIDTH-1:0] word_next;

  // A start bit is its own decoded MSB; later bits XOR against the previous decoded bit.
  always_comb begin
    bit_xfer  = bus.g_valid && bus.g_ready;
    out_xfer  = bus.bin_valid && bus.bin_ready;
    dec_bit   = (state == IDLE || bus.g_start) ? bus.g_in : (prev_bit ^ bus.g_in);
    word_next = {shift_reg, dec_bit};
    last_bit  = (state == SHIFT) && bit_xfer && !bus.g_start && (bit_cnt == CW'(WIDTH - 1));
    word_err  = 32'(word_next) > 32'd9;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bit_xfer && bus.g_start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = HOLD;
      HOLD:    if (bus.bin_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.g_ready   = (state != HOLD);
    bus.busy      = (state == SHIFT);
    bus.bin_valid = (state == HOLD);
    bus.bin_out   = bin_reg;
    bus.bcd_err   = bcd_reg;
    bus.err_count = err_reg;
  end

  // Result and flag are captured only on HOLD entry so they stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      prev_bit  <= 1'b0;
      bit_cnt   <= '0;
      bin_reg   <= '0;
      bcd_reg   <= 1'b0;
      err_reg   <= '0;
    end else begin
      if (bit_xfer && (bus.g_start || state == SHIFT)) begin
        prev_bit <= dec_bit;
        if (bus.g_start) begin
          shift_reg <= (WIDTH - 1)'(dec_bit);
          bit_cnt   <= CW'(1);
        end else begin
          shift_reg <= word_next[WIDTH-2:0];
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end
      if (last_bit) begin
        bin_reg <= word_next;
        bcd_reg <= word_err;
        if (word_err && err_reg != '1) err_reg <= err_reg + 1'b1;
      end
      if (out_xfer) begin
        bcd_reg <= 1'b0;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_bcd_serial.sv
// Directed bench for gray_to_bcd_serial: a word-level reference model checked every cycle,
// plus literal expectations for the decoded words.
module tb_gray_to_bcd_serial;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gray_to_bcd_serial_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gray_to_bcd_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects Gray bits of a word, converts the complete word arithmetically.
  logic             m_hold;
  logic             m_err;
  int               m_count;
  logic [WIDTH-1:0] m_word;
  logic             m_bits[$];

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold  = 1'b0;
      m_err   = 1'b0;
      m_count = 0;
      m_word  = '0;
      m_bits.delete();
    end else if (m_hold) begin
      if (bus.bin_ready) begin
        m_hold = 1'b0;
        m_err  = 1'b0;
      end
    end else if (bus.g_valid) begin
      if (bus.g_start) begin
        m_bits.delete();
        m_bits.push_back(bus.g_in);
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(bus.g_in);
      end
      if (m_bits.size() == WIDTH) begin
        logic [WIDTH-1:0] g;
        for (int i = 0; i < WIDTH; i++) g[WIDTH-1-i] = m_bits[i];
        m_word = gray2bin(g);
        m_err  = (m_word > 9);
        if (m_err && m_count < (1 << CNT_W) - 1) m_count++;
        m_hold = 1'b1;
        m_bits.delete();
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model g_ready", int'(bus.g_ready), int'(!m_hold));
      checkOutput("model busy", int'(bus.busy), int'(!m_hold && m_bits.size() > 0));
      checkOutput("model bin_valid", int'(bus.bin_valid), int'(m_hold));
      checkOutput("model err_count", int'(bus.err_count), m_count);
      if (m_hold) begin
        checkOutput("model bin_out", int'(bus.bin_out), int'(m_word));
        checkOutput("model bcd_err", int'(bus.bcd_err), int'(m_err));
      end
    end
  end

  task automatic applyStimulus(input logic g, input logic start, input logic valid);
    bus.g_in    = g;
    bus.g_start = start;
    bus.g_valid = valid;
    @(posedge clk);
    #2;
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] gray, input int gap);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(gray[i], i == WIDTH - 1, 1'b1);
      if (i > 0) for (int k = 0; k < gap; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    bus.g_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bus.g_in      = 1'b0;
    bus.g_start   = 1'b0;
    bus.g_valid   = 1'b0;
    bus.bin_ready = 1'b1;
    rst           = 1'b1;
    #3;
    checkOutput("reset g_ready", int'(bus.g_ready), 1);
    checkOutput("reset bin_valid", int'(bus.bin_valid), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset bin_out", int'(bus.bin_out), 0);
    checkOutput("reset err_count", int'(bus.err_count), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    sendWord(4'b0110, 0);
    checkOutput("w0110 valid", int'(bus.bin_valid), 1);
    checkOutput("w0110 bin", int'(bus.bin_out), 4);
    checkOutput("w0110 err", int'(bus.bcd_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("w0110 valid one cycle", int'(bus.bin_valid), 0);

    sendWord(4'b1101, 0);
    checkOutput("w1101 bin", int'(bus.bin_out), 9);
    checkOutput("w1101 err", int'(bus.bcd_err), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("hold drops bit", int'(bus.busy), 0);
    sendWord(4'b1111, 0);
    checkOutput("w1111 bin", int'(bus.bin_out), 10);
    checkOutput("w1111 err", int'(bus.bcd_err), 1);
    checkOutput("w1111 count", int'(bus.err_count), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bcd_err cleared", int'(bus.bcd_err), 0);

    bus.bin_ready = 1'b0;
    sendWord(4'b0110, 0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, (c % 2) == 0, 1'b1);
      checkOutput("bp valid", int'(bus.bin_valid), 1);
      checkOutput("bp bin", int'(bus.bin_out), 4);
      checkOutput("bp g_ready", int'(bus.g_ready), 0);
    end
    bus.bin_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp release", int'(bus.bin_valid), 0);
    sendWord(4'b0111, 0);
    checkOutput("w0111 bin", int'(bus.bin_out), 5);
    applyStimulus(1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("idle drop busy", int'(bus.busy), 0);
    end
    sendWord(4'b1101, 3);
    checkOutput("gap bin", int'(bus.bin_out), 9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    sendWord(4'b0110, 0);
    checkOutput("restart bin", int'(bus.bin_out), 4);
    applyStimulus(1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre-reset busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("async busy", int'(bus.busy), 0);
    checkOutput("async g_ready", int'(bus.g_ready), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sendWord(4'b0011, 0);
    checkOutput("post-reset bin", int'(bus.bin_out), 2);
    checkOutput("post-reset err", int'(bus.bcd_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    doReset();
    for (int n = 0; n < 5; n++) begin
      sendWord(4'b1111, 0);
      checkOutput("sat bcd_err", int'(bus.bcd_err), 1);
      checkOutput("sat err_count", int'(bus.err_count), (n < 3) ? n + 1 : 3);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
